control_sequencer: RTL and testbench

Hardwired control unit that drives the DataPath strobes. It fetches each instruction and executes it as a T0..T6 step sequence, decoding the IR value supplied by the DataPath. It sits directly upstream of the DataPath and replaces hand-driven control with real sequencing. It covers fetch, three-register ALU/shift ops, mul/div into HI/LO, nop and halt.

---
 rtl/control_sequencer.sv | 172 +++++++++++++++++
 tb/tb_control_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetches each instruction and runs it as a T0..T6 step
// sequence, decoding the IR supplied by the DataPath into datapath strobes.
`timescale 1ns/1ps
module control_sequencer #(
   parameter int         IR_WIDTH   = 32,
   parameter logic [4:0] ALU_MAX_OP = 5'b01100,
   parameter logic [4:0] MUL_OP     = 5'b01111,
   parameter logic [4:0] DIV_OP     = 5'b10000,
   parameter logic [4:0] NOP_OP     = 5'b11010,
   parameter logic [4:0] HALT_OP    = 5'b11011
) (
   input  logic                clock,
   input  logic                clear,
   input  logic [IR_WIDTH-1:0] IR,
   input  logic                stop,
   output logic                PCout,
   output logic                IncPC,
   output logic                MARin,
   output logic                Zin,
   output logic                Zlo_out,
   output logic                Zhi_out,
   output logic                PCin,
   output logic                Read,
   output logic                MDRin,
   output logic                MDRout,
   output logic                IRin,
   output logic                Yin,
   output logic                HIin,
   output logic                LOin,
   output logic [15:0]         Rin,
   output logic [15:0]         Rout,
   output logic [4:0]          opcode,
   output logic                Run,
   output logic                illegal
);

   // state | meaning
   // T0    | PC -> MAR, PC+1 -> Z
   // T1    | Z -> PC, memory read into MDR
   // T2    | MDR -> IR
   // T3    | Rb -> Y (ALU/mul/div); nop/halt/illegal finish here
   // T4    | Rc through ALU into Z
   // T5    | Zlo -> Ra (ALU) or LO (mul/div)
   // T6    | Zhi -> HI (mul/div only)
   // HALT  | idle until clear; bit 3 is the halt bit, bits 2:0 the step
   typedef enum logic [3:0] {
      T0   = 4'd0,
      T1   = 4'd1,
      T2   = 4'd2,
      T3   = 4'd3,
      T4   = 4'd4,
      T5   = 4'd5,
      T6   = 4'd6,
      HALT = 4'd8
   } state_t;

   state_t     state_q, state_d;
   logic       stop_pend_q, stop_pend_d;

   logic [4:0] op;
   logic [3:0] ra, rb, rc;
   logic       is_alu, is_md;
   state_t     after_last;
   logic       unused_ir;

   assign op        = IR[31:27];
   assign ra        = IR[26:23];
   assign rb        = IR[22:19];
   assign rc        = IR[18:15];
   assign unused_ir = ^IR[14:0];

   assign is_alu     = (op <= ALU_MAX_OP);
   assign is_md      = (op == MUL_OP) || (op == DIV_OP);
   assign after_last = (stop_pend_q || stop) ? HALT : T0;

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q     <= T0;
         stop_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         stop_pend_q <= stop_pend_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      stop_pend_d = (state_q == HALT) ? stop_pend_q : (stop_pend_q | stop);
      case (state_q)
         T0: state_d = T1;
         T1: state_d = T2;
         T2: state_d = T3;
         T3: begin
            if (is_alu || is_md)    state_d = T4;
            else if (op == HALT_OP) state_d = HALT;
            else                    state_d = after_last;
         end
         T4: state_d = T5;
         T5: state_d = is_md ? T6 : after_last;
         T6: state_d = after_last;
         default: state_d = HALT;
      endcase
   end

   // Outputs are forced low combinationally while clear is held so an abort
   // never lets a partial register load through.
   always_comb begin
      PCout   = 1'b0;
      IncPC   = 1'b0;
      MARin   = 1'b0;
      Zin     = 1'b0;
      Zlo_out = 1'b0;
      Zhi_out = 1'b0;
      PCin    = 1'b0;
      Read    = 1'b0;
      MDRin   = 1'b0;
      MDRout  = 1'b0;
      IRin    = 1'b0;
      Yin     = 1'b0;
      HIin    = 1'b0;
      LOin    = 1'b0;
      Rin     = 16'h0000;
      Rout    = 16'h0000;
      opcode  = 5'b00000;
      illegal = 1'b0;
      Run     = clear && (state_q != HALT);
      if (clear) begin
         case (state_q)
            T0: begin
               PCout = 1'b1;
               MARin = 1'b1;
               IncPC = 1'b1;
               Zin   = 1'b1;
            end
            T1: begin
               Zlo_out = 1'b1;
               PCin    = 1'b1;
               Read    = 1'b1;
               MDRin   = 1'b1;
            end
            T2: begin
               MDRout = 1'b1;
               IRin   = 1'b1;
            end
            T3: begin
               if (is_alu || is_md) begin
                  Rout = 16'd1 << rb;
                  Yin  = 1'b1;
               end else if (op != NOP_OP && op != HALT_OP) begin
                  illegal = 1'b1;
               end
            end
            T4: begin
               Rout   = 16'd1 << rc;
               opcode = op;
               Zin    = 1'b1;
            end
            T5: begin
               Zlo_out = 1'b1;
               if (is_md) LOin = 1'b1;
               else       Rin  = 16'd1 << ra;
            end
            T6: begin
               Zhi_out = 1'b1;
               HIin    = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: checks every step's strobes against
// hand-built expected vectors for fetch, ALU, mul/div, stop, halt and illegal.
`timescale 1ns/1ps
module tb_control_sequencer;

   logic        clock = 1'b0;
   logic        clear;
   logic [31:0] IR;
   logic        stop;
   logic        PCout, IncPC, MARin, Zin, Zlo_out, Zhi_out, PCin, Read, MDRin;
   logic        MDRout, IRin, Yin, HIin, LOin, Run, illegal;
   logic [15:0] Rin, Rout;
   logic [4:0]  opcode;

   int n_vec  = 0;
   int n_miss = 0;

   control_sequencer dut (
      .clock(clock), .clear(clear), .IR(IR), .stop(stop),
      .PCout(PCout), .IncPC(IncPC), .MARin(MARin), .Zin(Zin),
      .Zlo_out(Zlo_out), .Zhi_out(Zhi_out), .PCin(PCin), .Read(Read), .MDRin(MDRin),
      .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin),
      .Rin(Rin), .Rout(Rout), .opcode(opcode), .Run(Run), .illegal(illegal)
   );

   always #5 clock = ~clock;

   // strobe bit positions within the 15-bit strobe field
   localparam logic [14:0] S_PCOUT = 15'h4000, S_INCPC = 15'h2000, S_MARIN = 15'h1000,
                           S_ZIN   = 15'h0800, S_ZLO   = 15'h0400, S_ZHI   = 15'h0200,
                           S_PCIN  = 15'h0100, S_READ  = 15'h0080, S_MDRIN = 15'h0040,
                           S_MDROUT= 15'h0020, S_IRIN  = 15'h0010, S_YIN   = 15'h0008,
                           S_HIIN  = 15'h0004, S_LOIN  = 15'h0002, S_RUN   = 15'h0001;

   logic [52:0] obs;
   assign obs = {PCout, IncPC, MARin, Zin, Zlo_out, Zhi_out, PCin, Read, MDRin,
                 MDRout, IRin, Yin, HIin, LOin, Run, Rin, Rout, opcode, illegal};

   function automatic logic [52:0] mk(input logic [14:0] s, input logic [15:0] rin,
                                      input logic [15:0] rout, input logic [4:0] opc,
                                      input logic ill);
      return {s, rin, rout, opc, ill};
   endfunction

   localparam logic [52:0] E_ZERO = 53'd0;
   logic [52:0] e_t0, e_t1, e_t2;

   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic apply_reset();
      @(negedge clock);
      clear = 1'b0;
      stop  = 1'b0;
      step();
      clear = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      clear = 1'b0;
      stop  = 1'b0;
      IR    = 32'h2891_8000;
      #1;
      n_vec++;
      if (obs !== E_ZERO) begin
         n_miss++;
         $display("FAIL reset_hold: got %h expected %h", obs, E_ZERO);
      end
      repeat (3) @(posedge clock);
      @(negedge clock);
      clear = 1'b1;
      #1;
      n_vec++;
      if (obs !== e_t0) begin
         n_miss++;
         $display("FAIL reset_release_t0: got %h expected %h", obs, e_t0);
      end
      repeat (4) step();
      n_vec++;
      if (obs !== mk(S_ZIN | S_RUN, 16'h0, 16'h0008, 5'b00101, 1'b0)) begin
         n_miss++;
         $display("FAIL reset_pre_abort_t4: got %h", obs);
      end
      #2 clear = 1'b0;
      #1;
      n_vec++;
      if (obs !== E_ZERO) begin
         n_miss++;
         $display("FAIL reset_async_abort: got %h expected %h", obs, E_ZERO);
      end
      step();
      n_vec++;
      if (obs !== E_ZERO) begin
         n_miss++;
         $display("FAIL reset_abort_held: got %h expected %h", obs, E_ZERO);
      end
      clear = 1'b1;
      #1;
      n_vec++;
      if (obs !== e_t0) begin
         n_miss++;
         $display("FAIL reset_abort_t0: got %h expected %h", obs, e_t0);
      end
   endtask

   // starts and ends in T0
   task automatic test_alu(input string name, input logic [31:0] ir, input logic [4:0] op,
                           input int ra, input int rb, input int rc);
      logic [52:0] ev [6];
      ev[0] = e_t1;
      ev[1] = e_t2;
      ev[2] = mk(S_YIN | S_RUN, 16'h0, 16'd1 << rb, 5'b0, 1'b0);
      ev[3] = mk(S_ZIN | S_RUN, 16'h0, 16'd1 << rc, op, 1'b0);
      ev[4] = mk(S_ZLO | S_RUN, 16'd1 << ra, 16'h0, 5'b0, 1'b0);
      ev[5] = e_t0;
      IR = ir;
      for (int k = 0; k < 6; k++) begin
         step();
         n_vec++;
         if (obs !== ev[k]) begin
            n_miss++;
            $display("FAIL %s step T%0d: got %h expected %h", name, (k + 1) % 6, obs, ev[k]);
         end
      end
   endtask

   task automatic test_muldiv(input string name, input logic [31:0] ir, input logic [4:0] op,
                              input int rb, input int rc);
      logic [52:0] ev [7];
      ev[0] = e_t1;
      ev[1] = e_t2;
      ev[2] = mk(S_YIN | S_RUN, 16'h0, 16'd1 << rb, 5'b0, 1'b0);
      ev[3] = mk(S_ZIN | S_RUN, 16'h0, 16'd1 << rc, op, 1'b0);
      ev[4] = mk(S_ZLO | S_LOIN | S_RUN, 16'h0, 16'h0, 5'b0, 1'b0);
      ev[5] = mk(S_ZHI | S_HIIN | S_RUN, 16'h0, 16'h0, 5'b0, 1'b0);
      ev[6] = e_t0;
      IR = ir;
      for (int k = 0; k < 7; k++) begin
         step();
         n_vec++;
         if (obs !== ev[k]) begin
            n_miss++;
            $display("FAIL %s step T%0d: got %h expected %h", name, (k + 1) % 7, obs, ev[k]);
         end
      end
   endtask

   task automatic test_stop();
      IR = 32'h2891_8000;
      repeat (3) step();
      stop = 1'b1;
      step();
      stop = 1'b0;
      n_vec++;
      if (obs !== mk(S_ZIN | S_RUN, 16'h0, 16'h0008, 5'b00101, 1'b0)) begin
         n_miss++;
         $display("FAIL stop_t4: got %h", obs);
      end
      step();
      n_vec++;
      if (obs !== mk(S_ZLO | S_RUN, 16'h0002, 16'h0, 5'b0, 1'b0)) begin
         n_miss++;
         $display("FAIL stop_t5: got %h", obs);
      end
      for (int k = 0; k < 10; k++) begin
         step();
         if (k == 4) stop = 1'b1;
         if (k == 5) stop = 1'b0;
         n_vec++;
         if (obs !== E_ZERO) begin
            n_miss++;
            $display("FAIL stop_halt cycle %0d: got %h expected %h", k, obs, E_ZERO);
         end
      end
      // stop arriving only during the final step of a nop must still halt
      apply_reset();
      IR = 32'hD000_0000;
      repeat (3) step();
      n_vec++;
      if (obs !== mk(S_RUN, 16'h0, 16'h0, 5'b0, 1'b0)) begin
         n_miss++;
         $display("FAIL stop_last_nop_t3: got %h", obs);
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
      n_vec++;
      if (obs !== E_ZERO) begin
         n_miss++;
         $display("FAIL stop_last_halt: got %h expected %h", obs, E_ZERO);
      end
   endtask

   task automatic test_halt_illegal();
      apply_reset();
      IR = 32'hD800_0000;
      repeat (3) step();
      n_vec++;
      if (obs !== mk(S_RUN, 16'h0, 16'h0, 5'b0, 1'b0)) begin
         n_miss++;
         $display("FAIL halt_t3: got %h", obs);
      end
      repeat (2) begin
         step();
         n_vec++;
         if (obs !== E_ZERO) begin
            n_miss++;
            $display("FAIL halt_state: got %h expected %h", obs, E_ZERO);
         end
      end
      apply_reset();
      IR = 32'hF800_0000;
      repeat (3) step();
      n_vec++;
      if (obs !== mk(S_RUN, 16'h0, 16'h0, 5'b0, 1'b1)) begin
         n_miss++;
         $display("FAIL illegal_t3: got %h", obs);
      end
      step();
      n_vec++;
      if (obs !== e_t0) begin
         n_miss++;
         $display("FAIL illegal_next_t0: got %h expected %h", obs, e_t0);
      end
   endtask

   task automatic test_back_to_back();
      // nop followed directly by an ALU op with register 0 as the target
      IR = 32'hD000_0000;
      repeat (3) step();
      n_vec++;
      if (obs !== mk(S_RUN, 16'h0, 16'h0, 5'b0, 1'b0)) begin
         n_miss++;
         $display("FAIL b2b_nop_t3: got %h", obs);
      end
      step();
      n_vec++;
      if (obs !== e_t0) begin
         n_miss++;
         $display("FAIL b2b_nop_t0: got %h expected %h", obs, e_t0);
      end
      test_alu("b2b_add_r0", 32'h007F_8000, 5'b00000, 0, 15, 15);
   endtask

   initial begin
      e_t0 = mk(S_PCOUT | S_MARIN | S_INCPC | S_ZIN | S_RUN, 16'h0, 16'h0, 5'b0, 1'b0);
      e_t1 = mk(S_ZLO | S_PCIN | S_READ | S_MDRIN | S_RUN, 16'h0, 16'h0, 5'b0, 1'b0);
      e_t2 = mk(S_MDROUT | S_IRIN | S_RUN, 16'h0, 16'h0, 5'b0, 1'b0);
      test_reset();
      test_alu("shr", 32'h2891_8000, 5'b00101, 1, 2, 3);
      test_alu("shra", 32'h3091_8000, 5'b00110, 1, 2, 3);
      test_alu("shl", 32'h3891_8000, 5'b00111, 1, 2, 3);
      test_muldiv("mul", 32'h7891_8000, 5'b01111, 2, 3);
      test_muldiv("div", 32'h8091_8000, 5'b10000, 2, 3);
      test_back_to_back();
      test_stop();
      test_halt_illegal();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
